// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and types shared by the CPU front-end blocks.
//   RESET_PC      - PC loaded by reset
//   INSTR_BYTES   - size of one instruction in bytes (PC increment)
//   fetch_state_e - fetch FSM states
package cpu_pkg;

    localparam logic [31:0] RESET_PC    = 32'h8002_0000;
    localparam int          INSTR_BYTES = 4;

    // F_IDLE: nothing outstanding
    // F_WAIT: one request outstanding, its response will be kept
    // F_DROP: one request outstanding, its response will be thrown away
    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_WAIT = 2'd1,
        F_DROP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/pipe_buffer.sv
// pipe_buffer: 1-entry valid/ready register holding one PC/instruction pair.
//
// Ports:
//   clock, reset      - clock, synchronous active-high reset
//   flush_i           - drop the held entry (data registers keep their value)
//   in_valid_i        - load in_pc_i/in_instr_i this cycle (caller ensures free_o)
//   out_ready_i       - downstream accepts the held entry
//   out_valid_o       - entry held
//   out_pc_o/out_instr_o - held entry; stable while out_valid_o && !out_ready_i
//   free_o            - entry can be written this cycle (empty or draining)
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; the producer holds valid and data stable until that edge.
module pipe_buffer
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_pc_i,
    input  logic [WIDTH-1:0] in_instr_i,
    input  logic             out_ready_i,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_pc_o,
    output logic [WIDTH-1:0] out_instr_o,
    output logic             free_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] pc_q,    pc_d;
    logic [WIDTH-1:0] instr_q, instr_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (in_valid_i) begin
            valid_d = 1'b1;
            pc_d    = in_pc_i;
            instr_d = in_instr_i;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_pc_o    = pc_q;
    assign out_instr_o = instr_q;
    assign free_o      = !valid_q || out_ready_i;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, issues one instruction-memory request at a time
// and hands PC/instruction pairs to decode. Redirects from execute reload the
// PC, flush the output buffer and squash any outstanding request.
//
// Ports:
//   clock, reset                    - clock, synchronous active-high reset
//   redirect_valid, redirect_pc     - taken branch/jump target (low 2 bits ignored)
//   imem_req_valid/ready/addr       - request channel; addr is always the PC
//   imem_resp_valid/data            - in-order response, >=1 cycle after accept
//   out_valid/ready, out_pc/instr   - pair to decode
//   dbg_state                       - current fetch FSM state
//
// Handshake: every valid/ready channel transfers on a rising edge where both
// are high; the sender keeps valid and payload stable until that edge.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(cpu_pkg::RESET_PC)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [WIDTH-1:0] imem_req_addr,
    input  logic             imem_resp_valid,
    input  logic [WIDTH-1:0] imem_resp_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_pc,
    output logic [WIDTH-1:0] out_instr,
    output fetch_state_e     dbg_state
);

    localparam logic [WIDTH-1:0] PC_STEP    = WIDTH'(INSTR_BYTES);
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(INSTR_BYTES - 1);

    fetch_state_e     state_q, state_d;
    logic [WIDTH-1:0] pc_q,     pc_d;
    logic [WIDTH-1:0] req_pc_q, req_pc_d;

    logic buf_free;
    logic req_fire;
    logic fill;

    // Only issue when the buffer can take the response: the response cannot
    // come back before the next edge, and by then any held entry has drained.
    assign imem_req_valid = (state_q == F_IDLE) && buf_free && !redirect_valid && !reset;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign fill           = (state_q == F_WAIT) && imem_resp_valid && !redirect_valid;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        if (redirect_valid) begin
            // The outstanding request (if any) is wrong-path: drop its
            // response now if it is here, otherwise wait for it in F_DROP.
            pc_d = redirect_pc & ALIGN_MASK;
            case (state_q)
                F_WAIT, F_DROP: state_d = imem_resp_valid ? F_IDLE : F_DROP;
                default:        state_d = F_IDLE;
            endcase
        end else begin
            case (state_q)
                F_IDLE: begin
                    if (req_fire) begin
                        state_d  = F_WAIT;
                        req_pc_d = pc_q;
                        pc_d     = pc_q + PC_STEP;
                    end
                end
                F_WAIT, F_DROP: begin
                    if (imem_resp_valid) state_d = F_IDLE;
                end
                default: state_d = F_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= F_IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    assign dbg_state = state_q;

    pipe_buffer #(.WIDTH(WIDTH)) u_out_buf (
        .clock       (clock),
        .reset       (reset),
        .flush_i     (redirect_valid),
        .in_valid_i  (fill),
        .in_pc_i     (req_pc_q),
        .in_instr_i  (imem_resp_data),
        .out_ready_i (out_ready),
        .out_valid_o (out_valid),
        .out_pc_o    (out_pc),
        .out_instr_o (out_instr),
        .free_o      (buf_free)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: self-checking bench for fetch_stage. A behavioural imem
// answers each accepted request after a programmable latency; every accepted
// request pushes its expected PC/instruction pair, redirects and reset discard
// the pairs that must never reach decode, and deliveries are popped and compared.
module tb_fetch_stage;
    import cpu_pkg::*;

    localparam logic [31:0] RST_PC = 32'h8002_0000;

    logic         clock = 1'b0;
    logic         reset;
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    logic         imem_req_valid;
    logic         imem_req_ready;
    logic [31:0]  imem_req_addr;
    logic         imem_resp_valid;
    logic [31:0]  imem_resp_data;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_pc;
    logic [31:0]  out_instr;
    fetch_state_e dbg_state;

    fetch_stage #(.WIDTH(32), .RESET_PC(RST_PC)) dut (
        .clock           (clock),
        .reset           (reset),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_instr       (out_instr),
        .dbg_state       (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clock = ~clock;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard / imem model state ----------------
    logic [63:0] exp_q[$];       // {pc, instr} expected at decode
    logic [31:0] issued[$];      // every accepted request address
    logic [31:0] pend_addr[$];   // imem requests awaiting response
    int          pend_due[$];
    int          cyc;
    int          lat;
    int          n_deliv;
    logic [31:0] first_pc;
    bit          fired;
    int          n_cmp;
    int          n_err;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h0BAD_F00D;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- driver: one clock cycle ----------------
    // Called at a falling edge with the control inputs already set by the caller.
    task automatic tick();
        logic [63:0] e;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = instr_of(pend_addr[0]);
        end
        #1;
        if (imem_resp_valid) begin
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        if (reset) begin
            exp_q.delete();
            check("req_valid_in_reset", {31'd0, imem_req_valid}, 32'd0);
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_pc", out_pc, 32'hxxxx_xxxx);
                end else begin
                    e = exp_q.pop_front();
                    check("out_pc", out_pc, e[63:32]);
                    check("out_instr", out_instr, e[31:0]);
                end
                if (n_deliv == 0) first_pc = out_pc;
                n_deliv++;
            end
            // Everything not yet accepted by decode is wrong-path after a redirect.
            if (redirect_valid) exp_q.delete();
            if (imem_req_valid && imem_req_ready) begin
                issued.push_back(imem_req_addr);
                pend_addr.push_back(imem_req_addr);
                pend_due.push_back(cyc + lat);
                exp_q.push_back({imem_req_addr, instr_of(imem_req_addr)});
                fired = 1'b1;
            end
        end
        @(posedge clock);
        cyc++;
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        tick();
        tick();
        reset = 1'b0;
        pend_addr.delete();
        pend_due.delete();
        issued.delete();
        exp_q.delete();
        n_deliv = 0;
    endtask

    task automatic wait_fire();
        fired = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (fired) break;
        end
        if (!fired) check("wait_fire_timeout", 32'd0, 32'd1);
    endtask

    // ---------------- main sequence ----------------
    int n0;

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0; lat = 1; n_deliv = 0; first_pc = '0; fired = 1'b0;
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0; out_ready = 1'b1;
        @(negedge clock);

        // Reset state, sampled while reset is still asserted.
        reset = 1'b1;
        tick();
        tick();
        #1;
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_req_addr", imem_req_addr, RST_PC);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);

        // 1: straight-line fetch, 1-cycle latency, decode always ready.
        do_reset();
        lat = 1; imem_req_ready = 1'b1; out_ready = 1'b1;
        repeat (12) tick();
        check("t1_addr0", issued[0], RST_PC);
        check("t1_addr1", issued[1], RST_PC + 32'd4);
        check("t1_addr2", issued[2], RST_PC + 32'd8);
        check("t1_deliv", {31'd0, n_deliv >= 3}, 32'd1);

        // 2: decode stalls for 5 cycles right after the first delivery.
        do_reset();
        lat = 1; out_ready = 1'b1;
        n0 = 0;
        for (int i = 0; i < 20; i++) begin
            n0 = issued.size();
            tick();
            if (n_deliv > 0) break;
        end
        out_ready = 1'b0;
        repeat (5) tick();
        check("t2_req_cnt", 32'(issued.size() - n0), 32'd1);
        check("t2_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("t2_hold_valid", {31'd0, out_valid}, 32'd1);
        check("t2_hold_pc", out_pc, RST_PC + 32'd4);
        check("t2_hold_instr", out_instr, instr_of(RST_PC + 32'd4));
        out_ready = 1'b1;
        repeat (8) tick();
        check("t2_resume_addr", issued[n0 + 1], RST_PC + 32'd8);
        check("t2_deliv", {31'd0, n_deliv >= 3}, 32'd1);

        // 3: redirect while a 3-cycle request is outstanding.
        do_reset();
        lat = 3; out_ready = 1'b1;
        wait_fire();
        redirect_valid = 1'b1; redirect_pc = 32'h8002_0100;
        tick();
        redirect_valid = 1'b0;
        n0 = issued.size(); n_deliv = 0;
        repeat (15) tick();
        check("t3_next_addr", issued[n0], 32'h8002_0100);
        check("t3_first_pc", first_pc, 32'h8002_0100);

        // 4: redirect in the same cycle as the response.
        do_reset();
        lat = 1; out_ready = 1'b1;
        wait_fire();
        redirect_valid = 1'b1; redirect_pc = 32'h8002_0203;
        tick();
        redirect_valid = 1'b0;
        check("t4_flushed", {31'd0, out_valid}, 32'd0);
        check("t4_pc_aligned", imem_req_addr, 32'h8002_0200);
        n0 = issued.size(); n_deliv = 0;
        repeat (6) tick();
        check("t4_next_addr", issued[n0], 32'h8002_0200);
        check("t4_first_pc", first_pc, 32'h8002_0200);

        // 5: PC wraps past the top of the address space.
        do_reset();
        lat = 1; out_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        n0 = issued.size();
        repeat (8) tick();
        check("t5_addr_top", issued[n0], 32'hFFFF_FFFC);
        check("t5_addr_wrap", issued[n0 + 1], 32'h0000_0000);

        // 6: reset while a request is outstanding; stale response must vanish.
        do_reset();
        lat = 3; out_ready = 1'b1;
        wait_fire();
        imem_req_ready = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        tick();                       // stale response arrives in this cycle
        check("t6_stale_drop", {31'd0, out_valid}, 32'd0);
        tick();
        check("t6_stale_drop2", {31'd0, out_valid}, 32'd0);
        check("t6_pend_empty", 32'(pend_addr.size()), 32'd0);
        imem_req_ready = 1'b1;
        n0 = issued.size();
        repeat (6) tick();
        check("t6_first_addr", issued[n0], RST_PC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
